// File: rtl/alu_int_ar_flagger.sv
// Integer add/sub/set-less-than unit with registered result and compare flags.
// One-cycle latency, no backpressure; an op may be issued every cycle.
// Optional INC/DEC/NEG ops are compiled in when ALU_INT_AR_INCDEC_EN is defined.
module alu_int_ar_flagger #(
    parameter int WORDSIZE = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [WORDSIZE-1:0] input_a,
    input  logic [WORDSIZE-1:0] input_b,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    output logic                out_valid,
    output logic [WORDSIZE-1:0] result,
    output logic                flag_overflow,
    output logic                flag_equal,
    output logic                flag_not_equal,
    output logic                flag_greater,
    output logic                flag_less,
    output logic                flag_u_equal,
    output logic                flag_u_greater,
    output logic                flag_u_less,
    output logic                flag_illegal
);

    // Op code is {funct3, funct7}, funct3 in the upper bits.
    localparam logic [9:0] OP_ADD  = 10'b000_0000000;
    localparam logic [9:0] OP_SUB  = 10'b000_0100000;
    localparam logic [9:0] OP_SLT  = 10'b010_0000000;
    localparam logic [9:0] OP_SLTU = 10'b011_0000000;
`ifdef ALU_INT_AR_INCDEC_EN
    localparam logic [9:0] OP_INC  = 10'b000_0000001;
    localparam logic [9:0] OP_DEC  = 10'b000_0000010;
    localparam logic [9:0] OP_NEG  = 10'b000_0000011;

    localparam logic [WORDSIZE-1:0] SIGNED_MAX = {1'b0, {(WORDSIZE-1){1'b1}}};
    localparam logic [WORDSIZE-1:0] SIGNED_MIN = {1'b1, {(WORDSIZE-1){1'b0}}};
    localparam logic [WORDSIZE-1:0] ONE        = {{(WORDSIZE-1){1'b0}}, 1'b1};
`endif

    localparam int MSB = WORDSIZE - 1;

    logic [9:0]          op;
    logic [WORDSIZE-1:0] sum;
    logic [WORDSIZE-1:0] diff;
    logic                eq;
    logic                s_lt;
    logic                u_lt;

    logic [WORDSIZE-1:0] nxt_result;
    logic                nxt_overflow;
    logic                nxt_illegal;

    assign op   = {funct3, funct7};
    assign sum  = input_a + input_b;
    assign diff = input_a - input_b;
    assign eq   = (input_a == input_b);
    assign s_lt = ($signed(input_a) < $signed(input_b));
    assign u_lt = (input_a < input_b);

    // Decode the op and form the next result, overflow and illegal flags.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        nxt_result   = '0;
        nxt_overflow = 1'b0;
        nxt_illegal  = 1'b0;
        case (op)
            OP_ADD: begin
                nxt_result   = sum;
                nxt_overflow = (input_a[MSB] == input_b[MSB]) && (sum[MSB] != input_a[MSB]);
            end
            OP_SUB: begin
                nxt_result   = diff;
                nxt_overflow = (input_a[MSB] != input_b[MSB]) && (diff[MSB] != input_a[MSB]);
            end
            OP_SLT:  nxt_result = {{(WORDSIZE-1){1'b0}}, s_lt};
            OP_SLTU: nxt_result = {{(WORDSIZE-1){1'b0}}, u_lt};
`ifdef ALU_INT_AR_INCDEC_EN
            OP_INC: begin
                nxt_result   = input_a + ONE;
                nxt_overflow = (input_a == SIGNED_MAX);
            end
            OP_DEC: begin
                nxt_result   = input_a - ONE;
                nxt_overflow = (input_a == SIGNED_MIN);
            end
            OP_NEG:  nxt_result = ~input_a;
`endif
            default: nxt_illegal = 1'b1;
        endcase
    end

    // Output register: capture on accepted ops, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: reset clears every output register asynchronously so a
        // reset mid-run never exposes a stale result or flag.
        if (!rst_n) begin
            out_valid      <= 1'b0;
            result         <= '0;
            flag_overflow  <= 1'b0;
            flag_equal     <= 1'b0;
            flag_not_equal <= 1'b0;
            flag_greater   <= 1'b0;
            flag_less      <= 1'b0;
            flag_u_equal   <= 1'b0;
            flag_u_greater <= 1'b0;
            flag_u_less    <= 1'b0;
            flag_illegal   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together
            // from values sampled before the edge.
            out_valid <= in_valid;
            if (in_valid) begin
                result         <= nxt_result;
                flag_overflow  <= nxt_overflow;
                flag_equal     <= eq;
                flag_not_equal <= ~eq;
                flag_greater   <= ~eq & ~s_lt;
                flag_less      <= s_lt;
                flag_u_equal   <= eq;
                flag_u_greater <= ~eq & ~u_lt;
                flag_u_less    <= u_lt;
                flag_illegal   <= nxt_illegal;
            end
        end
    end

endmodule

// File: tb/tb_alu_int_ar_flagger.sv
// Scoreboard bench for alu_int_ar_flagger (WORDSIZE=64): directed ops push
// hand-computed expectations; a monitor pops and compares on out_valid.
module tb_alu_int_ar_flagger;

    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] result;
        logic [8:0]   flags; // {ov, eq, ne, gt, lt, ueq, ugt, ult, ill}
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] input_a = '0;
    logic [W-1:0] input_b = '0;
    logic [2:0]   funct3 = '0;
    logic [6:0]   funct7 = '0;
    logic         out_valid;
    logic [W-1:0] result;
    logic         flag_overflow, flag_equal, flag_not_equal, flag_greater, flag_less;
    logic         flag_u_equal, flag_u_greater, flag_u_less, flag_illegal;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t last_exp = '0;

    alu_int_ar_flagger #(.WORDSIZE(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .input_a(input_a), .input_b(input_b), .funct3(funct3), .funct7(funct7),
        .out_valid(out_valid), .result(result), .flag_overflow(flag_overflow),
        .flag_equal(flag_equal), .flag_not_equal(flag_not_equal),
        .flag_greater(flag_greater), .flag_less(flag_less),
        .flag_u_equal(flag_u_equal), .flag_u_greater(flag_u_greater),
        .flag_u_less(flag_u_less), .flag_illegal(flag_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] dut_flags();
        return {flag_overflow, flag_equal, flag_not_equal, flag_greater, flag_less,
                flag_u_equal, flag_u_greater, flag_u_less, flag_illegal};
    endfunction

    // Build an expectation; ne and u_equal follow from eq.
    function automatic exp_t mk(logic [W-1:0] res, logic ov, logic eq, logic gt, logic lt,
                                logic ugt, logic ult, logic ill);
        exp_t e;
        e.result = res;
        e.flags  = {ov, eq, ~eq, gt, lt, eq, ugt, ult, ill};
        return e;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Issue one op on the next cycle and record what it must produce.
    task automatic issue(input logic [2:0] f3, input logic [6:0] f7,
                         input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        funct3   = f3;
        funct7   = f7;
        input_a  = a;
        input_b  = b;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            input_a  = '1;
            input_b  = '0;
        end
    endtask

    // Monitor: compare on out_valid, otherwise outputs must hold.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", result, e.result);
                    check("flags", {55'd0, dut_flags()}, {55'd0, e.flags});
                    last_exp = e;
                end
            end else if (rst_n) begin
                check("hold_result", result, last_exp.result);
                check("hold_flags", {55'd0, dut_flags()}, {55'd0, last_exp.flags});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    localparam logic [W-1:0] MIN  = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] MAX  = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        #12;
        rst_n = 1'b1;

        // ADD 5+3
        issue(3'b000, 7'b0000000, 64'd5, 64'd3, mk(64'd8, 0, 0, 1, 0, 1, 0, 0));
        // SUB MIN-1 overflows
        issue(3'b000, 7'b0100000, MIN, 64'd1, mk(MAX, 1, 0, 0, 1, 1, 0, 0));
        // ADD -1+1 wraps, no overflow
        issue(3'b000, 7'b0000000, ALL1, 64'd1, mk(64'd0, 0, 0, 0, 1, 1, 0, 0));
        // SLT then SLTU back-to-back
        issue(3'b010, 7'b0000000, ALL1, 64'd1, mk(64'd1, 0, 0, 0, 1, 1, 0, 0));
        issue(3'b011, 7'b0000000, ALL1, 64'd1, mk(64'd0, 0, 0, 0, 1, 1, 0, 0));
        idle(2);
        // Op {000,0000001}: INC or illegal
`ifdef ALU_INT_AR_INCDEC_EN
        issue(3'b000, 7'b0000001, 64'd7, 64'd0, mk(64'd8, 0, 0, 1, 0, 1, 0, 0));
        issue(3'b000, 7'b0000001, MAX, 64'd0, mk(MIN, 1, 0, 1, 0, 1, 0, 0));
        issue(3'b000, 7'b0000010, MIN, 64'd0, mk(MAX, 1, 0, 0, 1, 1, 0, 0));
        issue(3'b000, 7'b0000011, 64'd5, 64'd5, mk(64'hFFFF_FFFF_FFFF_FFFA, 0, 1, 0, 0, 0, 0, 0));
`else
        issue(3'b000, 7'b0000001, 64'd7, 64'd0, mk(64'd0, 0, 0, 1, 0, 1, 0, 1));
        issue(3'b000, 7'b0000001, MAX, 64'd0, mk(64'd0, 0, 0, 1, 0, 1, 0, 1));
        issue(3'b000, 7'b0000010, MIN, 64'd0, mk(64'd0, 0, 0, 0, 1, 1, 0, 1));
        issue(3'b000, 7'b0000011, 64'd5, 64'd5, mk(64'd0, 0, 1, 0, 0, 0, 0, 1));
`endif
        // Equal operands
        issue(3'b000, 7'b0000000, 64'd9, 64'd9, mk(64'd18, 0, 1, 0, 0, 0, 0, 0));
        // ADD MAX+1 overflows
        issue(3'b000, 7'b0000000, MAX, 64'd1, mk(MIN, 1, 0, 1, 0, 1, 0, 0));
        idle(1);
        // SUB 3-5
        issue(3'b000, 7'b0100000, 64'd3, 64'd5, mk(64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 1, 0, 1, 0));
        // Unsupported funct3
        issue(3'b001, 7'b0000000, 64'd1, 64'd2, mk(64'd0, 0, 0, 0, 1, 0, 1, 1));
        // SLT / SLTU with 1 vs -1
        issue(3'b010, 7'b0000000, 64'd1, ALL1, mk(64'd0, 0, 0, 1, 0, 0, 1, 0));
        issue(3'b011, 7'b0000000, 64'd1, ALL1, mk(64'd1, 0, 0, 1, 0, 0, 1, 0));
        idle(3);

        // Reset mid-run with an op in flight: outputs clear without a clock edge.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        funct3   = 3'b000;
        funct7   = 7'b0000000;
        input_a  = 64'd100;
        input_b  = 64'd200;
        #2;
        rst_n = 1'b0;
        last_exp = '0;
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_flags", {55'd0, dut_flags()}, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;

        // First op after reset is accepted; in-flight op was discarded.
        issue(3'b000, 7'b0000000, 64'd2, 64'd2, mk(64'd4, 0, 1, 0, 0, 0, 0, 0));
        idle(4);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_int_ar_flagger.md
ALU_INT_AR_FLAGGER -- requirements
Module: alu_int_ar_flagger

Interface
REQ-001 SHALL have parameter WORDSIZE, default 64, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  operands/op sampled when high.
REQ-005 SHALL have port input_a  input  WORDSIZE  first operand.
REQ-006 SHALL have port input_b  input  WORDSIZE  second operand.
REQ-007 SHALL have port funct3  input  3  RISC-V funct3 field.
REQ-008 SHALL have port funct7  input  7  RISC-V funct7 field.
REQ-009 SHALL have port out_valid  output  1  result/flags valid.
REQ-010 SHALL have port result  output  WORDSIZE  operation result.
REQ-011 SHALL have port flag_overflow  output  1  signed overflow of ADD/SUB/INC/DEC.
REQ-012 SHALL have ports flag_equal, flag_not_equal, flag_greater, flag_less  output  1 each  signed compare of a vs b.
REQ-013 SHALL have ports flag_u_equal, flag_u_greater, flag_u_less  output  1 each  unsigned compare of a vs b.
REQ-014 SHALL have port flag_illegal  output  1  op code not supported.

Function
REQ-015 SHALL decode op = {funct3, funct7} (10 bits, funct3 in MSBs).
REQ-016 SHALL implement ADD {000,0000000}: a+b, modulo 2^WORDSIZE.
REQ-017 SHALL implement SUB {000,0100000}: a-b, modulo 2^WORDSIZE.
REQ-018 SHALL implement SLT {010,0000000}: result 1 if signed a<b else 0, zero-extended.
REQ-019 SHALL implement SLTU {011,0000000}: result 1 if unsigned a<b else 0, zero-extended.
REQ-020 SHALL, for any other op, drive result 0, flag_overflow 0, flag_illegal 1; compare flags still valid.
REQ-021 SHALL set flag_overflow for ADD when operands share sign and result sign differs; for SUB when operand signs differ and result sign differs from a; 0 for SLT/SLTU.
REQ-022 SHALL compute compare flags from sampled a,b on every accepted op regardless of opcode; u_equal equals equal; exactly one of equal/greater/less and of u_equal/u_greater/u_less is 1; not_equal = ~equal.
REQ-023 SHALL register all outputs: latency exactly 1 cycle from in_valid-high edge to out_valid-high.
REQ-024 SHALL drive out_valid = in_valid of previous cycle; no backpressure, back-to-back ops every cycle.
REQ-025 SHALL hold result and all flags unchanged while in_valid is low (out_valid low).

Reset
REQ-026 SHALL, while rst_n low, force out_valid, result, and every flag to 0 immediately, independent of clk.
REQ-027 SHALL accept the first op on the first rising clk edge after rst_n deasserts; an op in flight when reset asserts is discarded.

Configuration
REQ-028 SHALL support macro ALU_INT_AR_INCDEC_EN; when defined, add INC {000,0000001}: a+1, DEC {000,0000010}: a-1, NEG {000,0000011}: ~a (one's complement).
REQ-029 SHALL set flag_overflow for INC when a = 0x7FF..F and for DEC when a = 0x800..0; NEG overflow 0.
REQ-030 SHALL, when macro undefined, treat those three codes as illegal per REQ-020.

Verification (WORDSIZE=64)
REQ-031 SHALL test reset: rst_n=0 mid-run -> result=0, out_valid=0, all flags 0 without clock edge.
REQ-032 SHALL test ADD a=5,b=3 -> next cycle result=8, overflow=0, greater=1, u_greater=1, not_equal=1.
REQ-033 SHALL test SUB a=0x8000000000000000,b=1 -> result=0x7FFFFFFFFFFFFFFF, overflow=1, less=1, u_greater=1.
REQ-034 SHALL test ADD a=0xFFFFFFFFFFFFFFFF,b=1 -> result=0, overflow=0, less=1, u_greater=1.
REQ-035 SHALL test SLT then SLTU back-to-back with a=-1,b=1 -> results 1 then 0 on consecutive cycles.
REQ-036 SHALL test op {000,0000001} with a=7 -> macro off: result=0, illegal=1; macro on: result=8, illegal=0.
